// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package cpu_pkg;

    localparam int unsigned PC_W_DEF      = 10;
    localparam logic [31:0] HALT_WORD_DEF = 32'h0000_007F;
    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush-to-NOP beats load, load beats kill, otherwise hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = PC_W_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            kill,
    input  logic [31:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            valid
);

    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    // NOTE: hold values are assigned first so every path writes every signal; no latch is inferred.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end else if (kill) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM word index, and
// sequences run / halt-drain / halted / fault.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W         = PC_W_DEF,
    parameter int unsigned ROM_DEPTH    = 28,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF,
    parameter logic [31:0] NOP_WORD     = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [7:0]      rom_addr,
    input  logic [31:0]     rom_instr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc,
    output logic            if_id_valid,
    output logic            halted,
    output logic            fetch_fault
);

    localparam int unsigned IDX_W = PC_W - 2;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;

    logic             ifid_flush, ifid_load, ifid_kill;
    logic [IDX_W-1:0] word_idx;
    logic             idx_oob;
    logic [PC_W-1:0]  redirect_pc;
    logic             unused_target_lsbs;

    assign word_idx    = pc_q[PC_W-1:2];
    assign rom_addr    = 8'(word_idx);
    assign idx_oob     = 32'(word_idx) >= ROM_DEPTH;
    assign redirect_pc = {redirect_target[PC_W-1:2], 2'b00};
    // Target byte offset is meaningless for word-aligned fetch.
    assign unused_target_lsbs = ^redirect_target[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        ifid_kill  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    if (idx_oob) begin
                        state_d   = FAULT;
                        fault_d   = 1'b1;
                        ifid_kill = 1'b1;
                    end else begin
                        ifid_load = 1'b1;
                        // A halt word parks the PC on itself so a cancel can refetch cleanly.
                        if (rom_instr == HALT_WORD) begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end else begin
                            pc_d = pc_q + PC_W'(4);
                        end
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                    state_d    = RUN;
                end else begin
                    ifid_kill = !stall;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state_d   = HALTED;
                        halted_d  = 1'b1;
                        ifid_kill = 1'b1;
                    end
                end
            end
            HALTED, FAULT: begin
                ifid_kill = 1'b1;
            end
            default: begin
                ifid_kill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    if_id_reg #(
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (ifid_flush),
        .load     (ifid_load),
        .kill     (ifid_kill),
        .instr_in (rom_instr),
        .pc_in    (pc_q),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .valid    (if_id_valid)
    );

    assign halted      = halted_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural zero-latency ROM.
module tb_fetch_unit;

    localparam logic [31:0] HALT = 32'h0000_007F;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic [31:0] rom_instr;
    logic        stall;
    logic        redirect_valid;
    logic [9:0]  redirect_target;
    logic [31:0] if_id_instr;
    logic [9:0]  if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_fault;

    logic [31:0] rom [256];
    int checks;
    int failures;

    assign rom_instr = rom[rom_addr];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_addr        (rom_addr),
        .rom_instr       (rom_instr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic halt_at_5);
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        for (int i = 0; i < 256; i++) rom[i] = 32'(i + 1);
        if (halt_at_5) rom[5] = HALT;
        tick();
        tick();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        checks++; if (if_id_instr !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr, NOP); end
        checks++; if (if_id_pc !== 10'd0) begin failures++; $display("FAIL rst_pc got=%h exp=0", if_id_pc); end
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
        checks++; if (halted !== 1'b0 || fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", halted, fetch_fault); end
        checks++; if (rom_addr !== 8'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", rom_addr); end
        release_reset();
    endtask

    task automatic test_straight();
        apply_reset(1'b0);
        release_reset();
        checks++; if (rom_addr !== 8'd0) begin failures++; $display("FAIL seq_addr0 got=%0d exp=0", rom_addr); end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (rom_addr !== 8'(k + 1)) begin failures++; $display("FAIL seq_addr[%0d] got=%0d exp=%0d", k, rom_addr, k + 1); end
            checks++; if (if_id_pc !== 10'(4 * k)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, if_id_pc, 4 * k); end
            checks++; if (if_id_instr !== 32'(k + 1)) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, if_id_instr, k + 1); end
            checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, if_id_valid); end
        end
    endtask

    task automatic test_stall();
        apply_reset(1'b0);
        release_reset();
        tick();
        tick();
        checks++; if (rom_addr !== 8'd2) begin failures++; $display("FAIL stall_pre_addr got=%0d exp=2", rom_addr); end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (rom_addr !== 8'd2) begin failures++; $display("FAIL stall_addr[%0d] got=%0d exp=2", k, rom_addr); end
            checks++; if (if_id_pc !== 10'd4 || if_id_instr !== 32'd2) begin failures++; $display("FAIL stall_ifid[%0d] got=%h/%h exp=004/00000002", k, if_id_pc, if_id_instr); end
        end
        stall = 1'b0;
        tick();
        checks++; if (if_id_pc !== 10'd8 || if_id_instr !== 32'd3) begin failures++; $display("FAIL stall_resume0 got=%h/%h exp=008/00000003", if_id_pc, if_id_instr); end
        tick();
        checks++; if (if_id_pc !== 10'd12 || if_id_instr !== 32'd4) begin failures++; $display("FAIL stall_resume1 got=%h/%h exp=00c/00000004", if_id_pc, if_id_instr); end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        release_reset();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 10'd12;
        stall           = 1'b1;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", if_id_valid); end
        checks++; if (if_id_instr !== NOP) begin failures++; $display("FAIL redir_nop got=%h exp=%h", if_id_instr, NOP); end
        checks++; if (rom_addr !== 8'd3) begin failures++; $display("FAIL redir_addr got=%0d exp=3", rom_addr); end
        tick();
        checks++; if (if_id_pc !== 10'd12 || if_id_instr !== 32'd4 || if_id_valid !== 1'b1) begin failures++; $display("FAIL redir_fetch got=%h/%h/%b exp=00c/00000004/1", if_id_pc, if_id_instr, if_id_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b0);
        release_reset();
        redirect_valid  = 1'b1;
        redirect_target = 10'h010;
        tick();
        checks++; if (rom_addr !== 8'd4) begin failures++; $display("FAIL b2b_addr0 got=%0d exp=4", rom_addr); end
        redirect_target = 10'h022;
        tick();
        redirect_valid = 1'b0;
        checks++; if (rom_addr !== 8'd8 || if_id_valid !== 1'b0) begin failures++; $display("FAIL b2b_addr1 got=%0d/%b exp=8/0", rom_addr, if_id_valid); end
        tick();
        checks++; if (if_id_pc !== 10'h020 || if_id_instr !== 32'd9) begin failures++; $display("FAIL b2b_fetch got=%h/%h exp=020/00000009", if_id_pc, if_id_instr); end
    endtask

    task automatic test_halt();
        apply_reset(1'b1);
        release_reset();
        repeat (5) tick();
        checks++; if (rom_addr !== 8'd5 || if_id_pc !== 10'd16) begin failures++; $display("FAIL halt_pre got=%0d/%h exp=5/010", rom_addr, if_id_pc); end
        tick();
        checks++; if (if_id_instr !== HALT || if_id_valid !== 1'b1 || if_id_pc !== 10'd20) begin failures++; $display("FAIL halt_capture got=%h/%b/%h exp=%h/1/014", if_id_instr, if_id_valid, if_id_pc, HALT); end
        checks++; if (rom_addr !== 8'd5) begin failures++; $display("FAIL halt_pc_frozen got=%0d exp=5", rom_addr); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (halted !== 1'b0 || rom_addr !== 8'd5 || if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_drain[%0d] got=%b/%0d/%b exp=0/5/0", k, halted, rom_addr, if_id_valid); end
        end
        tick();
        checks++; if (halted !== 1'b1 || if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_set got=%b/%b exp=1/0", halted, if_id_valid); end
        redirect_valid  = 1'b1;
        redirect_target = 10'd0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b1 || rom_addr !== 8'd5 || if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_ignore_redir got=%b/%0d/%b exp=1/5/0", halted, rom_addr, if_id_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || rom_addr !== 8'd0) begin failures++; $display("FAIL halt_async_rst got=%b/%0d exp=0/0", halted, rom_addr); end
    endtask

    task automatic test_cancel_halt();
        apply_reset(1'b1);
        release_reset();
        repeat (6) tick();
        checks++; if (if_id_instr !== HALT || if_id_valid !== 1'b1) begin failures++; $display("FAIL cancel_capture got=%h/%b exp=%h/1", if_id_instr, if_id_valid, HALT); end
        redirect_valid  = 1'b1;
        redirect_target = 10'h02C;
        tick();
        redirect_valid = 1'b0;
        checks++; if (rom_addr !== 8'd11 || halted !== 1'b0 || if_id_valid !== 1'b0) begin failures++; $display("FAIL cancel_redir got=%0d/%b/%b exp=11/0/0", rom_addr, halted, if_id_valid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (halted !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 10'(44 + 4 * k) || if_id_instr !== 32'(12 + k)) begin
                failures++; $display("FAIL cancel_run[%0d] got=%b/%b/%h/%h exp=0/1/%h/%h", k, halted, if_id_valid, if_id_pc, if_id_instr, 44 + 4 * k, 12 + k);
            end
        end
    endtask

    task automatic test_fault();
        apply_reset(1'b0);
        release_reset();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 10'h070;
        tick();
        redirect_valid = 1'b0;
        checks++; if (rom_addr !== 8'd28 || fetch_fault !== 1'b0 || if_id_valid !== 1'b0) begin failures++; $display("FAIL fault_redir got=%0d/%b/%b exp=28/0/0", rom_addr, fetch_fault, if_id_valid); end
        tick();
        checks++; if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0) begin failures++; $display("FAIL fault_set got=%b/%b exp=1/0", fetch_fault, if_id_valid); end
        redirect_valid  = 1'b1;
        redirect_target = 10'd0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b1 || rom_addr !== 8'd28) begin failures++; $display("FAIL fault_sticky got=%b/%0d exp=1/28", fetch_fault, rom_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fetch_fault !== 1'b0 || halted !== 1'b0 || rom_addr !== 8'd0) begin failures++; $display("FAIL fault_async_rst got=%b/%b/%0d exp=0/0/0", fetch_fault, halted, rom_addr); end
    endtask

    task automatic test_fault_boundary();
        apply_reset(1'b0);
        release_reset();
        redirect_valid  = 1'b1;
        redirect_target = 10'h06C;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (fetch_fault !== 1'b0 || if_id_valid !== 1'b1 || if_id_instr !== 32'd28 || if_id_pc !== 10'h06C) begin
            failures++; $display("FAIL edge_last_word got=%b/%b/%h/%h exp=0/1/0000001c/06c", fetch_fault, if_id_valid, if_id_instr, if_id_pc);
        end
        tick();
        checks++; if (fetch_fault !== 1'b1 || rom_addr !== 8'd28) begin failures++; $display("FAIL edge_fault got=%b/%0d exp=1/28", fetch_fault, rom_addr); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_cancel_halt();
        test_fault();
        test_fault_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
